// File: rtl/note_lane_dropper.sv
// One falling note in one rhythm lane: delay, fall, judge keypress.
// Define NOTE_REPEAT_EN to respawn the note REPEAT_GAP frames after DONE.
module note_lane_dropper #(
  parameter logic [7:0]  LANE_KEY    = 8'h52,
  parameter logic [7:0]  START_KEY   = 8'h2C,
  parameter logic [7:0]  CLEAR_KEY   = 8'h01,
  parameter logic [9:0]  X_POS       = 10'd440,
  parameter logic [9:0]  Y_START     = 10'd100,
  parameter logic [9:0]  Y_MAX       = 10'd400,
  parameter logic [9:0]  NOTE_H      = 10'd40,
  parameter logic [3:0]  SPEED       = 4'd1,
  parameter logic [11:0] START_DELAY = 12'd2680,
  parameter logic [9:0]  HIT_LO      = 10'd340,
  parameter logic [9:0]  PERFECT_Y   = 10'd380,
  parameter logic [9:0]  PERFECT_TOL = 10'd4,
  parameter logic [11:0] REPEAT_GAP  = 12'd120
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode_second,
  output logic [9:0] dropX,
  output logic [9:0] dropY,
  output logic       visible,
  output logic       hit,
  output logic       perfect,
  output logic       miss,
  output logic       score_pulse
);

`ifdef NOTE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  // Zero-length delays and gaps behave as a single frame
  localparam logic [11:0] WAIT_LAST =
    (START_DELAY == 12'd0) ? 12'd0 : START_DELAY - 12'd1;
  localparam logic [11:0] GAP_LAST =
    (REPEAT_GAP == 12'd0) ? 12'd0 : REPEAT_GAP - 12'd1;

  localparam logic [10:0] LIM    = {1'b0, Y_MAX};
  localparam logic [10:0] Y_LIM  = {1'b0, Y_MAX} - {1'b0, NOTE_H};
  localparam logic [10:0] LO     = {1'b0, HIT_LO};
  localparam logic [10:0] PY     = {1'b0, PERFECT_Y};
  localparam logic [10:0] TOL    = {1'b0, PERFECT_TOL};

  typedef enum logic [1:0] {
    IDLE, WAIT, FALL, DONE
  } state_t;

  state_t      state;
  logic [11:0] counter;
  logic        key_prev;
  logic        pressed;
  logic        press_edge;
  logic [10:0] bottom;
  logic [10:0] y_sum;
  logic [9:0]  y_next;
  logic [10:0] dev;
  logic        is_perfect;

  assign dropX      = X_POS;
  assign pressed    = (keycode == LANE_KEY) |
                      (keycode_second == LANE_KEY);
  assign press_edge = pressed & ~key_prev;
  assign bottom     = {1'b0, dropY} + {1'b0, NOTE_H};
  assign y_sum      = {1'b0, dropY} + {7'd0, SPEED};
  assign y_next     = (y_sum > Y_LIM) ? Y_LIM[9:0] : y_sum[9:0];
  assign dev        = (bottom >= PY) ? bottom - PY : PY - bottom;
  assign is_perfect = (dev <= TOL);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state       <= IDLE;
      counter     <= 12'd0;
      dropY       <= Y_START;
      visible     <= 1'b0;
      hit         <= 1'b0;
      perfect     <= 1'b0;
      miss        <= 1'b0;
      score_pulse <= 1'b0;
      key_prev    <= 1'b0;
    end else begin
      key_prev    <= pressed;
      score_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (keycode == START_KEY) begin
            counter <= 12'd0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (counter == WAIT_LAST) begin
            counter <= 12'd0;
            dropY   <= Y_START;
            visible <= 1'b1;
            state   <= FALL;
          end else begin
            counter <= counter + 12'd1;
          end
        end
        FALL: begin
          counter <= 12'd0;
          if (bottom >= LIM) begin
            miss    <= 1'b1;
            visible <= 1'b0;
            state   <= DONE;
          end else if (press_edge && bottom >= LO) begin
            hit         <= 1'b1;
            perfect     <= is_perfect;
            score_pulse <= 1'b1;
            visible     <= 1'b0;
            state       <= DONE;
          end else begin
            visible <= 1'b1;
            dropY   <= y_next;
          end
        end
        DONE: begin
          if (keycode == CLEAR_KEY) begin
            counter <= 12'd0;
            dropY   <= Y_START;
            visible <= 1'b0;
            hit     <= 1'b0;
            perfect <= 1'b0;
            miss    <= 1'b0;
            state   <= IDLE;
          end else if (REP_EN && counter == GAP_LAST) begin
            counter <= 12'd0;
            dropY   <= Y_START;
            visible <= 1'b1;
            hit     <= 1'b0;
            perfect <= 1'b0;
            miss    <= 1'b0;
            state   <= FALL;
          end else if (REP_EN) begin
            counter <= counter + 12'd1;
          end
        end
        default: begin
          counter <= 12'd0;
          dropY   <= Y_START;
          visible <= 1'b0;
          hit     <= 1'b0;
          perfect <= 1'b0;
          miss    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_lane_dropper.sv
// Directed bench for note_lane_dropper (slow and fast lanes).
// Covers reset, timing, hit window, edge detect, clamp and repeat.
module tb_note_lane_dropper;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic [7:0] keycode_second = 8'h00;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic a_vis, a_hit, a_perf, a_miss, a_sp;
  logic b_vis, b_hit, b_perf, b_miss, b_sp;

  int errors = 0;
  int checks = 0;

  always #5 frame_clk = ~frame_clk;

  note_lane_dropper #(
    .SPEED(4'd1), .START_DELAY(12'd4), .REPEAT_GAP(12'd3)
  ) u_a (
    .frame_clk(frame_clk), .Reset(Reset),
    .keycode(keycode), .keycode_second(keycode_second),
    .dropX(a_x), .dropY(a_y), .visible(a_vis), .hit(a_hit),
    .perfect(a_perf), .miss(a_miss), .score_pulse(a_sp)
  );

  note_lane_dropper #(
    .SPEED(4'd7), .START_DELAY(12'd4), .REPEAT_GAP(12'd3)
  ) u_b (
    .frame_clk(frame_clk), .Reset(Reset),
    .keycode(keycode), .keycode_second(keycode_second),
    .dropX(b_x), .dropY(b_y), .visible(b_vis), .hit(b_hit),
    .perfect(b_perf), .miss(b_miss), .score_pulse(b_sp)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  // Arm then run the 4 delay frames; leaves note visible at Y=100
  task automatic arm_to_fall();
    keycode = 8'h2C;
    tick();
    keycode = 8'h00;
    tick(4);
  endtask

  initial begin
    // Reset state
    tick();
    Reset = 1'b0;
    chk("rst_y", a_y, 100);
    chk("rst_x", a_x, 440);
    chk("rst_vis", a_vis, 0);
    chk("rst_flags", {a_hit, a_perf, a_miss, a_sp}, 0);
    tick(3);
    chk("idle_vis", a_vis, 0);

    // Reset mid-fall
    arm_to_fall();
    tick(100);
    chk("mid_y", a_y, 200);
    chk("mid_vis", a_vis, 1);
    do_reset();
    chk("mr_y", a_y, 100);
    chk("mr_vis", a_vis, 0);
    chk("mr_flags", {a_hit, a_perf, a_miss, a_sp}, 0);
    tick(6);
    chk("mr_idle", a_vis, 0);

    // Delay timing and miss at the bottom
    keycode = 8'h2C;
    tick();
    keycode = 8'h00;
    tick(3);
    chk("wait_vis", a_vis, 0);
    tick();
    chk("fall_vis", a_vis, 1);
    chk("fall_y0", a_y, 100);
    tick();
    chk("fall_y1", a_y, 101);
    tick(259);
    chk("pre_miss_y", a_y, 360);
    chk("pre_miss", a_miss, 0);
    tick();
    chk("miss", a_miss, 1);
    chk("miss_hit", a_hit, 0);
    chk("miss_vis", a_vis, 0);
    chk("miss_y", a_y, 360);
    keycode = 8'h2C;
    tick();
    chk("done_start_ign", a_miss, 1);
    keycode = 8'h01;
    tick();
    keycode = 8'h00;
    chk("clr_miss", a_miss, 0);
    chk("clr_y", a_y, 100);
    chk("clr_vis", a_vis, 0);

    // Perfect hit at bottom=380
    do_reset();
    arm_to_fall();
    tick(240);
    chk("perf_pre_y", a_y, 340);
    keycode = 8'h52;
    tick();
    keycode = 8'h00;
    chk("perf_hit", a_hit, 1);
    chk("perf_perf", a_perf, 1);
    chk("perf_sp", a_sp, 1);
    chk("perf_vis", a_vis, 0);
    chk("perf_y", a_y, 340);
    tick();
    chk("perf_sp_off", a_sp, 0);
    chk("perf_hold", {a_hit, a_perf}, 2'b11);
    chk("perf_y_frz", a_y, 340);

    // Early press ignored, good hit on secondary keycode
    do_reset();
    arm_to_fall();
    tick(199);
    keycode_second = 8'h52;
    tick();
    keycode_second = 8'h00;
    chk("early_hit", a_hit, 0);
    chk("early_y", a_y, 300);
    tick(5);
    chk("good_pre_y", a_y, 305);
    keycode_second = 8'h52;
    tick();
    keycode_second = 8'h00;
    chk("good_hit", a_hit, 1);
    chk("good_perf", a_perf, 0);
    chk("good_sp", a_sp, 1);

    // Held key never scores
    do_reset();
    keycode_second = 8'h52;
    tick(2);
    arm_to_fall();
    tick(260);
    chk("hold_y", a_y, 360);
    tick();
    chk("hold_miss", a_miss, 1);
    chk("hold_hit", a_hit, 0);

    // Release then re-press at bottom=350
    do_reset();
    tick();
    arm_to_fall();
    tick(209);
    keycode_second = 8'h00;
    tick();
    chk("rel_hit", a_hit, 0);
    chk("rel_y", a_y, 310);
    keycode_second = 8'h52;
    tick();
    keycode_second = 8'h00;
    chk("repress_hit", a_hit, 1);
    chk("repress_perf", a_perf, 0);

    // Fast lane: clamp to 360 then miss
    do_reset();
    arm_to_fall();
    chk("fast_y0", b_y, 100);
    tick(37);
    chk("fast_y37", b_y, 359);
    tick();
    chk("fast_clamp", b_y, 360);
    chk("fast_nomiss", b_miss, 0);
    tick();
    chk("fast_miss", b_miss, 1);
    chk("fast_miss_y", b_y, 360);
    tick(2);
    chk("gap_miss", b_miss, 1);
    chk("gap_vis", b_vis, 0);
    tick();
`ifdef NOTE_REPEAT_EN
    chk("rep_vis", b_vis, 1);
    chk("rep_y", b_y, 100);
    chk("rep_miss", b_miss, 0);
    tick(38);
    chk("rep_clamp", b_y, 360);
    tick();
    chk("rep_miss2", b_miss, 1);
    tick();
`else
    chk("term_miss", b_miss, 1);
    chk("term_vis", b_vis, 0);
`endif
    keycode = 8'h01;
    tick();
    keycode = 8'h00;
    chk("fast_clr_miss", b_miss, 0);
    chk("fast_clr_y", b_y, 100);
    chk("fast_clr_vis", b_vis, 0);
    tick(5);
    chk("fast_idle", b_vis, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_lane_dropper.md
Name: note_lane_dropper

Overview:
Parametrised successor of the single-arrow dropper. Drives one falling note in one rhythm lane: waits a programmable frame delay, falls at a programmable speed, and judges a keypress inside the hit window. Results are HIT (PERFECT or GOOD) or MISS. One instance per lane/note sits between the keyboard keycode path and the colour mapper/score logic, all on the frame clock.

Parameters:
LANE_KEY, 8'h52, keycode that scores this lane
START_KEY, 8'h2C, keycode that arms the block from IDLE
CLEAR_KEY, 8'h01, keycode that returns DONE to IDLE
X_POS, 10'd440, constant note X (left edge)
Y_START, 10'd100, note top Y at spawn
Y_MAX, 10'd400, bottom limit; note bottom reaching it is a miss
NOTE_H, 10'd40, note height (bottom = Y + NOTE_H)
SPEED, 4'd1, pixels per frame while falling (1..15)
START_DELAY, 12'd2680, frames from arming to start of fall
HIT_LO, 10'd340, hit window lower bound on note bottom (inclusive)
PERFECT_Y, 10'd380, ideal note bottom
PERFECT_TOL, 10'd4, max |bottom - PERFECT_Y| for PERFECT
REPEAT_GAP, 12'd120, frames between repeats (optional feature only)

Ports:
frame_clk  in  1  frame-rate clock, all logic on rising edge
Reset  in  1  synchronous, active-high
keycode  in  8  primary USB keycode
keycode_second  in  8  secondary USB keycode
dropX  out  10  note X, always X_POS
dropY  out  10  note top Y
visible  out  1  note should be drawn
hit  out  1  level: resolved as hit
perfect  out  1  level: hit was PERFECT (valid when hit=1)
miss  out  1  level: resolved as miss
score_pulse  out  1  one-frame pulse on the frame a hit is registered

Behaviour:
- Reset (sync): state=IDLE, counter=0, dropY=Y_START, visible=0, hit=perfect=miss=score_pulse=0, key_prev=0. Reset overrides any state, mid-fall included.
- pressed = (keycode==LANE_KEY)|(keycode_second==LANE_KEY). key_prev <= pressed every frame in every state. press_edge = pressed & ~key_prev. A key held from before never scores.
- bottom = dropY + NOTE_H, computed at 11 bits so it cannot wrap.
- IDLE: outputs held at reset values. If keycode==START_KEY: counter<=0 and go to WAIT (next frame).
- WAIT: visible=0. counter increments each frame. When counter==START_DELAY-1, go to FALL; dropY stays Y_START. START_DELAY=0 behaves as 1.
- FALL: visible=1. Each frame, evaluated in priority order:
  1. bottom >= Y_MAX: go to DONE, miss<=1, visible<=0.
  2. press_edge & bottom >= HIT_LO & bottom < Y_MAX: go to DONE, hit<=1, score_pulse<=1 for exactly this one frame, perfect<=(|bottom-PERFECT_Y| <= PERFECT_TOL), visible<=0.
  3. Otherwise dropY <= min(dropY+SPEED, Y_MAX-NOTE_H). The clamp makes rule 1 fire on the frame after the note lands at the limit.
- DONE: dropY frozen. hit/perfect/miss held. score_pulse=0. If keycode==CLEAR_KEY, go to IDLE with all outputs cleared on entry (dropY=Y_START). START_KEY is ignored in DONE.
- Keycodes are sampled only at the frame_clk edge. No other latency.
- State encoding is free. Unused states recover to IDLE.

Optional Feature:
NOTE_REPEAT_EN.
- Defined: in DONE, a counter runs REPEAT_GAP frames. When it expires, the block clears hit/perfect/miss, sets dropY=Y_START and counter=0, and re-enters FALL directly, skipping WAIT. This repeats until CLEAR_KEY. CLEAR_KEY during the gap still goes to IDLE. score_pulse fires once per repeat hit.
- Not defined: DONE is terminal until CLEAR_KEY. REPEAT_GAP is unused.

Test Plan:
1. Reset mid-FALL (dropY=200) -> next frame: dropY=100, visible=0, all flags 0, state IDLE.
2. START_DELAY=4, SPEED=1, START_KEY pulse -> visible rises 5 frames after arming. dropY advances 1/frame. With no press, miss=1 when dropY=360 (bottom=400). hit stays 0.
3. Press 8'h52 on the frame bottom=380 -> hit=1, perfect=1, score_pulse high for exactly 1 frame, dropY frozen at 340.
4. Press on keycode_second when bottom=345 -> hit=1, perfect=0. Press when bottom=339 -> ignored, fall continues.
5. Hold 8'h52 from IDLE through the whole fall -> no hit (no edge), miss=1. Release and re-press at bottom=350 in a separate run -> hit=1.
6. SPEED=7 from Y_START=100 -> dropY clamps to 360, then miss the next frame. CLEAR_KEY in DONE -> IDLE with flags cleared. With NOTE_REPEAT_EN and REPEAT_GAP=3 -> FALL re-entered 3 frames after DONE at dropY=100.
